// File: rtl/dpll_pkg.sv
// Shared DPLL types. N_BIT normally comes from config.sv; the guard below gives a default
// when this slice is compiled on its own.
`ifndef N_BIT
`define N_BIT 16
`endif

package dpll_pkg;

    typedef enum logic {
        WAIT_REF = 1'b0,
        MEASURE  = 1'b1
    } meas_state_t;

endpackage

// File: rtl/phase_meas_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// Raw edge to pulse is exactly three clock cycles.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic pulse_r;

    // synchroniser chain, edge history and one-cycle rising-edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            meta_r  <= sig_in;
            sync_r  <= meta_r;
            prev_r  <= sync_r;
            pulse_r <= sync_r & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/phase_meas.sv
// DPLL measurement front end: times ref_in period and the ref-to-fb phase split in Clock
// cycles, publishing results with a one-cycle ready pulse (timeout when ref is lost).
`ifndef N_BIT
`define N_BIT 16
`endif

module phase_meas
    import dpll_pkg::*;
#(
    parameter int N_BIT       = `N_BIT,
    parameter int TIMEOUT_CNT = 2**N_BIT - 1
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             ref_in,
    input  logic             fb_in,
    output logic [N_BIT-1:0] f_in,
    output logic [N_BIT-1:0] diff_1,
    output logic [N_BIT-1:0] diff_2,
    output logic             first_second,
    output logic             timeout,
    output logic             ready
);

    localparam logic [N_BIT-1:0] TO_VAL   = N_BIT'(TIMEOUT_CNT);
    localparam logic [N_BIT-1:0] ALL_ONES = {N_BIT{1'b1}};
    localparam logic [N_BIT-1:0] ZERO     = {N_BIT{1'b0}};
    localparam logic [N_BIT-1:0] ONE      = N_BIT'(1);

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    logic             rpulse_s;
    logic             fpulse_s;

    meas_state_t      state_r,   state_s;
    logic [N_BIT-1:0] cnt_r,     cnt_s;
    logic [N_BIT-1:0] t_r,       t_s;
    logic             fb_seen_r, fb_seen_s;
    logic [N_BIT-1:0] f_in_r,    f_in_s;
    logic [N_BIT-1:0] diff_1_r,  diff_1_s;
    logic [N_BIT-1:0] diff_2_r,  diff_2_s;
    logic             fs_r,      fs_s;
    logic             timeout_r, timeout_s;
    logic             ready_r,   ready_s;
    logic [N_BIT-1:0] rest_s;

    // reset: asynchronous assertion, release synchronised to Clock
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    edge_sync u_ref_sync (.clk(Clock), .rst_n(rst_n_s), .sig_in(ref_in), .pulse(rpulse_s));
    edge_sync u_fb_sync  (.clk(Clock), .rst_n(rst_n_s), .sig_in(fb_in),  .pulse(fpulse_s));

    assign rest_s = cnt_r - t_r;

    // next-state and result logic; cnt holds cycles elapsed since the opening ref pulse
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        t_s       = t_r;
        fb_seen_s = fb_seen_r;
        f_in_s    = f_in_r;
        diff_1_s  = diff_1_r;
        diff_2_s  = diff_2_r;
        fs_s      = fs_r;
        timeout_s = 1'b0;
        ready_s   = 1'b0;
        case (state_r)
            WAIT_REF: begin
                if (rpulse_s) begin
                    state_s   = MEASURE;
                    cnt_s     = ONE;
                    t_s       = ZERO;
                    fb_seen_s = fpulse_s;
                end else begin
                    state_s   = WAIT_REF;
                end
            end
            MEASURE: begin
                if (rpulse_s) begin
                    f_in_s    = cnt_r;
                    ready_s   = 1'b1;
                    if (fb_seen_r) begin
                        diff_1_s = t_r;
                        diff_2_s = rest_s;
                        fs_s     = (t_r <= rest_s);
                    end else begin
                        diff_1_s = cnt_r;
                        diff_2_s = ZERO;
                        fs_s     = 1'b0;
                    end
                    // closing edge also opens the next window; a coincident fb belongs to it
                    cnt_s     = ONE;
                    t_s       = ZERO;
                    fb_seen_s = fpulse_s;
                end else if (cnt_r == TO_VAL) begin
                    state_s   = WAIT_REF;
                    timeout_s = 1'b1;
                    ready_s   = 1'b1;
                    f_in_s    = ALL_ONES;
                    diff_1_s  = ZERO;
                    diff_2_s  = ZERO;
                    fs_s      = 1'b0;
                end else begin
                    if (cnt_r != ALL_ONES) begin
                        cnt_s = cnt_r + ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                    if (fpulse_s && !fb_seen_r) begin
                        t_s       = cnt_r;
                        fb_seen_s = 1'b1;
                    end else begin
                        fb_seen_s = fb_seen_r;
                    end
                end
            end
            default: begin
                state_s = WAIT_REF;
            end
        endcase
    end

    // state, window and output registers
    always_ff @(posedge Clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r   <= WAIT_REF;
            cnt_r     <= ZERO;
            t_r       <= ZERO;
            fb_seen_r <= 1'b0;
            f_in_r    <= ZERO;
            diff_1_r  <= ZERO;
            diff_2_r  <= ZERO;
            fs_r      <= 1'b0;
            timeout_r <= 1'b0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            t_r       <= t_s;
            fb_seen_r <= fb_seen_s;
            f_in_r    <= f_in_s;
            diff_1_r  <= diff_1_s;
            diff_2_r  <= diff_2_s;
            fs_r      <= fs_s;
            timeout_r <= timeout_s;
            ready_r   <= ready_s;
        end
    end

    assign f_in         = f_in_r;
    assign diff_1       = diff_1_r;
    assign diff_2       = diff_2_r;
    assign first_second = fs_r;
    assign timeout      = timeout_r;
    assign ready        = ready_r;

endmodule
